alu_arbiter: RTL and testbench

- Shares one registered ALU between two independent requesters.
- Arbitrates with round-robin priority and drives the ALU's A/B/EN/ALU_FUN inputs.
- Captures ALU_OUT after a fixed, parameterised latency and returns it to the winning requester on a valid/ready response channel.
- Sits between the requesting sequencers and the ALU instance; exactly one operation is in flight at a time.

---
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one registered ALU between two requesters. A round-robin grant is
// made in IDLE. The winner's operands are latched onto the ALU inputs, and
// ALU_EN is pulsed for one cycle. ALU_OUT is captured ALU_LAT cycles after
// that pulse. The result is then returned on the winner's valid/ready
// response channel. Only one operation is in flight at a time.
//
// Ports:
//   CLK, RST                       clock (rising edge), async active-high reset
//   REQx_VALID/READY/A/B/FUN       request channels (READY is combinational)
//   RSPx_VALID/READY/DATA          response channels (VALID/DATA registered)
//   ALU_A/ALU_B/ALU_FUN/ALU_EN     drive the shared ALU (registered)
//   ALU_OUT                        result from the shared ALU
//   BUSY                           high whenever the FSM is not IDLE
module alu_arbiter #(
   parameter int WIDTH   = 8,
   parameter int FUN_W   = 4,
   parameter int OUT_W   = 16,
   parameter int ALU_LAT = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             REQ0_VALID,
   output logic             REQ0_READY,
   input  logic [WIDTH-1:0] REQ0_A,
   input  logic [WIDTH-1:0] REQ0_B,
   input  logic [FUN_W-1:0] REQ0_FUN,
   input  logic             REQ1_VALID,
   output logic             REQ1_READY,
   input  logic [WIDTH-1:0] REQ1_A,
   input  logic [WIDTH-1:0] REQ1_B,
   input  logic [FUN_W-1:0] REQ1_FUN,
   output logic             RSP0_VALID,
   input  logic             RSP0_READY,
   output logic [OUT_W-1:0] RSP0_DATA,
   output logic             RSP1_VALID,
   input  logic             RSP1_READY,
   output logic [OUT_W-1:0] RSP1_DATA,
   output logic [WIDTH-1:0] ALU_A,
   output logic [WIDTH-1:0] ALU_B,
   output logic [FUN_W-1:0] ALU_FUN,
   output logic             ALU_EN,
   input  logic [OUT_W-1:0] ALU_OUT,
   output logic             BUSY
);

   // The counter must hold ALU_LAT-1.
   localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                    state_reg;
   logic                      ptr_reg;
   logic                      gid_reg;
   logic [CNT_W-1:0]          cnt_reg;
   logic [WIDTH-1:0]          alu_a_reg;
   logic [WIDTH-1:0]          alu_b_reg;
   logic [FUN_W-1:0]          alu_fun_reg;
   logic                      alu_en_reg;
   logic [1:0]                rsp_valid_reg;
   logic [1:0][OUT_W-1:0]     rsp_data_reg;

   logic [1:0]                req_valid;
   logic [1:0]                rsp_ready;
   logic [1:0][WIDTH-1:0]     req_a;
   logic [1:0][WIDTH-1:0]     req_b;
   logic [1:0][FUN_W-1:0]     req_fun;
   logic [1:0]                grant;
   logic                      grant_id;
   logic                      any_grant;

   assign req_valid = {REQ1_VALID, REQ0_VALID};
   assign rsp_ready = {RSP1_READY, RSP0_READY};
   assign req_a     = {REQ1_A, REQ0_A};
   assign req_b     = {REQ1_B, REQ0_B};
   assign req_fun   = {REQ1_FUN, REQ0_FUN};

   // A requester wins if it is the only one that is valid. It also wins if
   // both are valid and the pointer names it.
   for (genvar gi = 0; gi < 2; gi++) begin : g_grant
      assign grant[gi] = req_valid[gi] & (~req_valid[1-gi] | (ptr_reg == 1'(gi)));
   end

   assign grant_id  = grant[1];
   assign any_grant = |grant;

   // READY is masked while RST is high. This keeps a request from looking
   // accepted while the FSM is held in reset.
   assign REQ0_READY = (state_reg == IDLE) & ~RST & grant[0];
   assign REQ1_READY = (state_reg == IDLE) & ~RST & grant[1];

   assign ALU_A      = alu_a_reg;
   assign ALU_B      = alu_b_reg;
   assign ALU_FUN    = alu_fun_reg;
   assign ALU_EN     = alu_en_reg;
   assign RSP0_VALID = rsp_valid_reg[0];
   assign RSP1_VALID = rsp_valid_reg[1];
   assign RSP0_DATA  = rsp_data_reg[0];
   assign RSP1_DATA  = rsp_data_reg[1];
   assign BUSY       = (state_reg != IDLE);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg     <= IDLE;
         ptr_reg       <= 1'b0;
         gid_reg       <= 1'b0;
         cnt_reg       <= '0;
         alu_a_reg     <= '0;
         alu_b_reg     <= '0;
         alu_fun_reg   <= '0;
         alu_en_reg    <= 1'b0;
         rsp_valid_reg <= '0;
         rsp_data_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (any_grant) begin
                  alu_a_reg   <= req_a[grant_id];
                  alu_b_reg   <= req_b[grant_id];
                  alu_fun_reg <= req_fun[grant_id];
                  gid_reg     <= grant_id;
                  ptr_reg     <= ~grant_id;
                  // ALU_EN is raised on entry to ISSUE, so it is high
                  // exactly during the ISSUE cycle.
                  alu_en_reg  <= 1'b1;
                  state_reg   <= ISSUE;
               end
            end
            ISSUE: begin
               alu_en_reg <= 1'b0;
               cnt_reg    <= CNT_W'(ALU_LAT - 1);
               state_reg  <= WAIT;
            end
            WAIT: begin
               if (cnt_reg == '0) begin
                  rsp_data_reg[gid_reg]  <= ALU_OUT;
                  rsp_valid_reg[gid_reg] <= 1'b1;
                  state_reg              <= RESP;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready[gid_reg]) begin
                  rsp_valid_reg[gid_reg] <= 1'b0;
                  state_reg              <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
   localparam int LAT0 = 1;
   localparam int LAT1 = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Shared request/response-ready stimulus drives both instances.
   logic       v0, v1, rdy0, rdy1;
   logic [7:0] a0, b0, a1, b1;
   logic [3:0] f0, f1;

   // Instance 0 (ALU_LAT=1) outputs.
   logic        r0_0, r1_0, rv0_0, rv1_0, en_0, busy_0;
   logic [15:0] d0_0, d1_0, alu_out_0;
   logic [7:0]  aa_0, ab_0;
   logic [3:0]  af_0;
   // Instance 1 (ALU_LAT=3) outputs.
   logic        r0_1, r1_1, rv0_1, rv1_1, en_1, busy_1;
   logic [15:0] d0_1, d1_1, alu_out_1;
   logic [7:0]  aa_1, ab_1;
   logic [3:0]  af_1;

   alu_arbiter #(.WIDTH(8), .FUN_W(4), .OUT_W(16), .ALU_LAT(LAT0)) dut0 (
      .CLK(clk), .RST(rst),
      .REQ0_VALID(v0), .REQ0_READY(r0_0), .REQ0_A(a0), .REQ0_B(b0), .REQ0_FUN(f0),
      .REQ1_VALID(v1), .REQ1_READY(r1_0), .REQ1_A(a1), .REQ1_B(b1), .REQ1_FUN(f1),
      .RSP0_VALID(rv0_0), .RSP0_READY(rdy0), .RSP0_DATA(d0_0),
      .RSP1_VALID(rv1_0), .RSP1_READY(rdy1), .RSP1_DATA(d1_0),
      .ALU_A(aa_0), .ALU_B(ab_0), .ALU_FUN(af_0), .ALU_EN(en_0),
      .ALU_OUT(alu_out_0), .BUSY(busy_0));

   alu_arbiter #(.WIDTH(8), .FUN_W(4), .OUT_W(16), .ALU_LAT(LAT1)) dut1 (
      .CLK(clk), .RST(rst),
      .REQ0_VALID(v0), .REQ0_READY(r0_1), .REQ0_A(a0), .REQ0_B(b0), .REQ0_FUN(f0),
      .REQ1_VALID(v1), .REQ1_READY(r1_1), .REQ1_A(a1), .REQ1_B(b1), .REQ1_FUN(f1),
      .RSP0_VALID(rv0_1), .RSP0_READY(rdy0), .RSP0_DATA(d0_1),
      .RSP1_VALID(rv1_1), .RSP1_READY(rdy1), .RSP1_DATA(d1_1),
      .ALU_A(aa_1), .ALU_B(ab_1), .ALU_FUN(af_1), .ALU_EN(en_1),
      .ALU_OUT(alu_out_1), .BUSY(busy_1));

   function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] fn);
      case (fn)
         4'h0:    return {8'h00, a} + {8'h00, b};
         4'h1:    return {8'h00, a} - {8'h00, b};
         4'h2:    return {8'h00, a} * {8'h00, b};
         default: return {a ^ b, fn, 4'h5};
      endcase
   endfunction

   // Stub ALUs: the result is visible only during the single cycle that
   // follows LAT edges after EN. Every other cycle shows a poison value, so a
   // mistimed capture is caught.
   always @(posedge clk) alu_out_0 <= en_0 ? alu_f(aa_0, ab_0, af_0) : 16'hDEAD;

   logic [15:0] dl3 [3];
   always @(posedge clk) begin
      dl3[0] <= en_1 ? alu_f(aa_1, ab_1, af_1) : 16'hDEAD;
      dl3[1] <= dl3[0];
      dl3[2] <= dl3[1];
   end
   assign alu_out_1 = dl3[2];

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: k = cycles since grant (0 = idle).
   int          m_k [2];
   int          m_g [2];
   int          m_ptr [2];
   logic [7:0]  m_a [2];
   logic [7:0]  m_b [2];
   logic [3:0]  m_f [2];
   logic [15:0] m_rsp [2][2];
   int          gq[$];
   int          gc[$];
   int          exp_order [4] = '{0, 1, 0, 1};

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_k[d] = 0; m_g[d] = 0; m_ptr[d] = 0;
         m_a[d] = '0; m_b[d] = '0; m_f[d] = '0;
         m_rsp[d][0] = '0; m_rsp[d][1] = '0;
      end
   endtask

   function automatic int winner(input int ptr);
      if (v0 && v1) return ptr;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   task automatic chk(input string tag, input int d, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d cycle %0d: observed %h expected %h", tag, d, cyc, obs, exp);
      end
   endtask

   task automatic check_dut(input int d, input int lat, input logic r0, input logic r1,
                            input logic bz, input logic e, input logic [7:0] aa,
                            input logic [7:0] ab, input logic [3:0] af,
                            input logic rv0, input logic rv1,
                            input logic [15:0] d0, input logic [15:0] d1);
      int w;
      w = (m_k[d] == 0) ? winner(m_ptr[d]) : -1;
      chk("req0_ready", d, 16'(r0), 16'(w == 0));
      chk("req1_ready", d, 16'(r1), 16'(w == 1));
      chk("busy", d, 16'(bz), 16'(m_k[d] != 0));
      chk("alu_en", d, 16'(e), 16'(m_k[d] == 1));
      chk("alu_a", d, 16'(aa), 16'(m_a[d]));
      chk("alu_b", d, 16'(ab), 16'(m_b[d]));
      chk("alu_fun", d, 16'(af), 16'(m_f[d]));
      chk("rsp0_valid", d, 16'(rv0), 16'(m_k[d] >= 2 + lat && m_g[d] == 0));
      chk("rsp1_valid", d, 16'(rv1), 16'(m_k[d] >= 2 + lat && m_g[d] == 1));
      chk("rsp0_data", d, d0, m_rsp[d][0]);
      chk("rsp1_data", d, d1, m_rsp[d][1]);
   endtask

   task automatic zero_dut(input int d, input logic r0, input logic r1, input logic bz,
                           input logic e, input logic [7:0] aa, input logic [7:0] ab,
                           input logic [3:0] af, input logic rv0, input logic rv1,
                           input logic [15:0] d0, input logic [15:0] d1);
      chk("rst_req0_ready", d, 16'(r0), 16'h0);
      chk("rst_req1_ready", d, 16'(r1), 16'h0);
      chk("rst_busy", d, 16'(bz), 16'h0);
      chk("rst_alu_en", d, 16'(e), 16'h0);
      chk("rst_alu_a", d, 16'(aa), 16'h0);
      chk("rst_alu_b", d, 16'(ab), 16'h0);
      chk("rst_alu_fun", d, 16'(af), 16'h0);
      chk("rst_rsp0_valid", d, 16'(rv0), 16'h0);
      chk("rst_rsp1_valid", d, 16'(rv1), 16'h0);
      chk("rst_rsp0_data", d, d0, 16'h0);
      chk("rst_rsp1_data", d, d1, 16'h0);
   endtask

   task automatic check_reset_both();
      zero_dut(0, r0_0, r1_0, busy_0, en_0, aa_0, ab_0, af_0, rv0_0, rv1_0, d0_0, d1_0);
      zero_dut(1, r0_1, r1_1, busy_1, en_1, aa_1, ab_1, af_1, rv0_1, rv1_1, d0_1, d1_1);
   endtask

   task automatic model_step(input int d, input int lat);
      int w;
      if (m_k[d] == 0) begin
         w = winner(m_ptr[d]);
         if (w >= 0) begin
            m_k[d] = 1; m_g[d] = w; m_ptr[d] = 1 - w;
            m_a[d] = (w == 0) ? a0 : a1;
            m_b[d] = (w == 0) ? b0 : b1;
            m_f[d] = (w == 0) ? f0 : f1;
         end
      end else begin
         if (m_k[d] == 1 + lat) m_rsp[d][m_g[d]] = alu_f(m_a[d], m_b[d], m_f[d]);
         if (m_k[d] >= 2 + lat && ((m_g[d] == 0) ? rdy0 : rdy1)) m_k[d] = 0;
         else m_k[d]++;
      end
   endtask

   // Called just after an edge with inputs already driven for this cycle.
   task automatic settle();
      #1;
      check_dut(0, LAT0, r0_0, r1_0, busy_0, en_0, aa_0, ab_0, af_0, rv0_0, rv1_0, d0_0, d1_0);
      check_dut(1, LAT1, r0_1, r1_1, busy_1, en_1, aa_1, ab_1, af_1, rv0_1, rv1_1, d0_1, d1_1);
      if (r0_0) begin gq.push_back(0); gc.push_back(cyc); end
      if (r1_0) begin gq.push_back(1); gc.push_back(cyc); end
      model_step(0, LAT0);
      model_step(1, LAT1);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         settle();
         advance();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      v0 = 1'b0; v1 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_reset_both();
      rst = 1'b0;
      model_reset();
      cyc = 0;
      gq.delete(); gc.delete();
   endtask

   initial begin
      rst = 1'b1;
      v0 = 0; v1 = 0; rdy0 = 1; rdy1 = 1;
      a0 = 0; b0 = 0; f0 = 0; a1 = 0; b1 = 0; f1 = 0;
      model_reset();
      do_reset();

      // Single op on requester 0.
      v0 = 1; a0 = 8'h12; b0 = 8'h34; f0 = 4'h0;
      settle(); chk("single_ready0", 0, 16'(r0_0), 16'h1); advance();
      v0 = 0;
      settle();
      chk("single_en_c1", 0, 16'(en_0), 16'h1);
      chk("single_alu_a", 0, 16'(aa_0), 16'h12);
      chk("single_alu_b", 0, 16'(ab_0), 16'h34);
      advance();
      settle(); chk("single_en_c2", 0, 16'(en_0), 16'h0); advance();
      settle();
      chk("single_rsp0_valid_c3", 0, 16'(rv0_0), 16'h1);
      chk("single_rsp0_data", 0, d0_0, 16'h0046);
      chk("single_rsp1_valid", 0, 16'(rv1_0), 16'h0);
      chk("lat3_rsp0_valid_c3", 1, 16'(rv0_1), 16'h0);
      advance();
      settle(); chk("lat3_rsp0_valid_c4", 1, 16'(rv0_1), 16'h0); advance();
      settle();
      chk("lat3_rsp0_valid_c5", 1, 16'(rv0_1), 16'h1);
      chk("lat3_rsp0_data", 1, d0_1, 16'h0046);
      advance();
      tick(3);

      // Simultaneous requests straight after reset: grants alternate.
      do_reset();
      v0 = 1; a0 = 8'h05; b0 = 8'h07; f0 = 4'h2;
      v1 = 1; a1 = 8'h40; b1 = 8'h11; f1 = 4'h1;
      tick(16);
      chk("alt_grant_count", 0, 16'(gq.size()), 16'd4);
      for (int i = 0; i < 4 && i < gq.size(); i++)
         chk("alt_grant_order", 0, 16'(gq[i]), 16'(exp_order[i]));

      // Fairness: a lone requester-1 grant hands priority to requester 0.
      do_reset();
      v1 = 1;
      settle(); advance();
      v0 = 1;
      tick(6);
      v0 = 0; v1 = 0;
      chk("fair_grant_count", 0, 16'(gq.size()), 16'd2);
      if (gq.size() >= 2) begin
         chk("fair_first", 0, 16'(gq[0]), 16'd1);
         chk("fair_second", 0, 16'(gq[1]), 16'd0);
      end
      tick(8);

      // Backpressure: RSP0_READY low for 5 cycles while requester 1 waits.
      do_reset();
      v0 = 1; rdy0 = 0;
      settle(); advance();
      v0 = 0; v1 = 1;
      tick(7);
      rdy0 = 1;
      tick(3);
      v1 = 0;
      chk("bp_grant_count", 0, 16'(gq.size()), 16'd2);
      if (gq.size() >= 2) begin
         chk("bp_second_id", 0, 16'(gq[1]), 16'd1);
         chk("bp_second_cycle", 0, 16'(gc[1] - gc[0]), 16'd9);
      end
      tick(8);

      // Reset during WAIT aborts the op asynchronously.
      do_reset();
      v0 = 1; a0 = 8'hA5; b0 = 8'h3C; f0 = 4'h3;
      v1 = 1; a1 = 8'h11; b1 = 8'h22; f1 = 4'h0;
      settle(); advance();
      v0 = 0; v1 = 0;
      settle(); advance();
      settle();
      rst = 1'b1;
      #1;
      check_reset_both();
      @(posedge clk);
      #1;
      v0 = 1;
      #1;
      chk("rst_hold_ready0", 0, 16'(r0_0), 16'h0);
      chk("rst_hold_ready0", 1, 16'(r0_1), 16'h0);
      v0 = 0;
      rst = 1'b0;
      model_reset();
      gq.delete(); gc.delete();
      tick(8);
      v0 = 1; v1 = 1;
      tick(2);
      v0 = 0; v1 = 0;
      chk("rst_ptr_grant_count", 0, 16'(gq.size()), 16'd1);
      if (gq.size() >= 1) chk("rst_ptr_first", 0, 16'(gq[0]), 16'd0);
      tick(8);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         v0   = ($urandom_range(0, 3) != 0);
         v1   = ($urandom_range(0, 3) != 0);
         a0   = 8'($urandom); b0 = 8'($urandom); f0 = 4'($urandom_range(0, 15));
         a1   = 8'($urandom); b1 = 8'($urandom); f1 = 4'($urandom_range(0, 15));
         rdy0 = ($urandom_range(0, 3) != 0);
         rdy1 = ($urandom_range(0, 3) != 0);
         tick(1);
      end
      v0 = 0; v1 = 0; rdy0 = 1; rdy1 = 1;
      tick(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
